// File: rtl/pin_debouncer.sv
// pin_debouncer: debounces a raw asynchronous pin into a committed level plus
//    one-cycle rise/fall pulses.
// Latency: 2 synchronizer cycles + STABLE_CNT sample ticks (worst case
//    2 + STABLE_CNT*RATIO + 1 cycles) from a clean pin edge to btn_level.
// Backpressure: none; outputs are status/pulses, there is no consumer handshake.
// Ports:
//    pin_clk    - clock, all state on rising edge
//    pin_rst    - asynchronous active-low reset
//    pin_btn    - raw pin, possibly bouncing
//    btn_level  - debounced committed level
//    btn_rise   - one-cycle pulse on committed 0->1
//    btn_fall   - one-cycle pulse on committed 1->0
//    btn_busy   - high while a level change is being qualified
//    btn_toggle - flips on each committed rise when PIN_DEBOUNCER_TOGGLE_EN
//                 is defined; tied 0 otherwise (no flop)
// Optional feature macro: PIN_DEBOUNCER_TOGGLE_EN
module pin_debouncer #(
   parameter int unsigned RATIO      = 10,
   parameter int unsigned STABLE_CNT = 4
) (
   input  logic pin_clk,
   input  logic pin_rst,
   input  logic pin_btn,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall,
   output logic btn_busy,
   output logic btn_toggle
);

   localparam int unsigned   CW       = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CW-1:0] TICK_MAX = CW'(RATIO - 1);
   localparam logic [7:0]    STAB_MAX = 8'(STABLE_CNT);

   typedef enum logic [1:0] {S_LO, S_LO2HI, S_HI, S_HI2LO} state_t;

   logic          meta_q, sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick;
   state_t        state_q, state_d;
   logic [7:0]    stab_q, stab_d;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   // Sample tick: counter restarts at 0 out of reset, so the first tick is
   // RATIO cycles after release. With RATIO=1 the counter stays 0 and tick
   // is permanently high.
   assign tick  = (cnt_q == TICK_MAX);
   assign cnt_d = tick ? '0 : cnt_q + CW'(1);

   always_comb begin
      state_d = state_q;
      stab_d  = stab_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (tick) begin
         case (state_q)
            S_LO: begin
               if (sync_q) begin
                  if (STABLE_CNT == 1) begin
                     state_d = S_HI;
                     level_d = 1'b1;
                     rise_d  = 1'b1;
                     stab_d  = 8'd0;
                  end else begin
                     state_d = S_LO2HI;
                     stab_d  = 8'd1;
                  end
               end
            end
            S_LO2HI: begin
               if (!sync_q) begin
                  // Bounce: abandon silently.
                  state_d = S_LO;
                  stab_d  = 8'd0;
               end else if (stab_q + 8'd1 == STAB_MAX) begin
                  state_d = S_HI;
                  level_d = 1'b1;
                  rise_d  = 1'b1;
                  stab_d  = 8'd0;
               end else begin
                  stab_d  = stab_q + 8'd1;
               end
            end
            S_HI: begin
               if (!sync_q) begin
                  if (STABLE_CNT == 1) begin
                     state_d = S_LO;
                     level_d = 1'b0;
                     fall_d  = 1'b1;
                     stab_d  = 8'd0;
                  end else begin
                     state_d = S_HI2LO;
                     stab_d  = 8'd1;
                  end
               end
            end
            S_HI2LO: begin
               if (sync_q) begin
                  state_d = S_HI;
                  stab_d  = 8'd0;
               end else if (stab_q + 8'd1 == STAB_MAX) begin
                  state_d = S_LO;
                  level_d = 1'b0;
                  fall_d  = 1'b1;
                  stab_d  = 8'd0;
               end else begin
                  stab_d  = stab_q + 8'd1;
               end
            end
            default: begin
               state_d = S_LO;
               stab_d  = 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge pin_clk or negedge pin_rst) begin
      if (!pin_rst) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         cnt_q   <= '0;
         state_q <= S_LO;
         stab_q  <= 8'd0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         meta_q  <= pin_btn;
         sync_q  <= meta_q;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         stab_q  <= stab_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign btn_level = level_q;
   assign btn_rise  = rise_q;
   assign btn_fall  = fall_q;
   assign btn_busy  = (state_q == S_LO2HI) || (state_q == S_HI2LO);

`ifdef PIN_DEBOUNCER_TOGGLE_EN
   logic toggle_q;
   // Flips on the same edge that raises btn_rise.
   always_ff @(posedge pin_clk or negedge pin_rst) begin
      if (!pin_rst) toggle_q <= 1'b0;
      else if (rise_d) toggle_q <= ~toggle_q;
   end
   assign btn_toggle = toggle_q;
`else
   assign btn_toggle = 1'b0;
`endif

endmodule

// File: tb/tb_pin_debouncer.sv
// tb_pin_debouncer: directed bench for pin_debouncer (RATIO=10/STABLE_CNT=4
//    main instance, RATIO=1/STABLE_CNT=1 edge instance).
// Latency: n/a. Backpressure: n/a.
module tb_pin_debouncer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, btn, btn_e;
   logic lvl, rise, fall, busy, tog;
   logic lvl_e, rise_e, fall_e, busy_e, tog_e;

`ifdef PIN_DEBOUNCER_TOGGLE_EN
   localparam bit TOG_EN = 1'b1;
`else
   localparam bit TOG_EN = 1'b0;
`endif

   pin_debouncer #(.RATIO(10), .STABLE_CNT(4)) dut (
      .pin_clk(clk), .pin_rst(rst_n), .pin_btn(btn),
      .btn_level(lvl), .btn_rise(rise), .btn_fall(fall),
      .btn_busy(busy), .btn_toggle(tog)
   );

   pin_debouncer #(.RATIO(1), .STABLE_CNT(1)) dut_e (
      .pin_clk(clk), .pin_rst(rst_n), .pin_btn(btn_e),
      .btn_level(lvl_e), .btn_rise(rise_e), .btn_fall(fall_e),
      .btn_busy(busy_e), .btn_toggle(tog_e)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic overlap_seen = 1'b0;

   always @(negedge clk) begin
      if ((rise && fall) || (rise_e && fall_e)) overlap_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive the main pin to 'target' and watch 60 cycles.
   task automatic run_edge(input logic target, output int first, output int n_rise,
                           output int n_fall, output int busy_hi, output int busy_late);
      first = -1; n_rise = 0; n_fall = 0; busy_hi = 0; busy_late = 0;
      btn = target;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); @(negedge clk);
         if (rise) n_rise++;
         if (fall) n_fall++;
         if (busy) busy_hi++;
         if (first < 0 && lvl == target) first = i;
         else if (first >= 0 && busy) busy_late++;
      end
   endtask

   task automatic press(input string tag, input int idx);
      int first, nr, nf, bh, bl;
      run_edge(1'b1, first, nr, nf, bh, bl);
      check({tag, "_rise_cnt"}, nr, 1);
      check({tag, "_fall_cnt"}, nf, 0);
      check({tag, "_lat_ok"}, (first > 0 && first <= 43), 1);
      check({tag, "_busy_seen"}, (bh > 0), 1);
      check({tag, "_busy_after"}, bl, 0);
      check({tag, "_level"}, lvl, 1);
      check({tag, "_toggle"}, tog, (TOG_EN && (idx % 2 == 1)) ? 1 : 0);
   endtask

   task automatic release_btn(input string tag);
      int first, nr, nf, bh, bl;
      run_edge(1'b0, first, nr, nf, bh, bl);
      check({tag, "_fall_cnt"}, nf, 1);
      check({tag, "_rise_cnt"}, nr, 0);
      check({tag, "_lat_ok"}, (first > 0 && first <= 43), 1);
      check({tag, "_level"}, lvl, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      int first, nr, bs, at;
      rst_n = 1'b0; btn = 1'b0; btn_e = 1'b0;
      #12;
      check("rst_level", lvl, 0);
      check("rst_rise", rise, 0);
      check("rst_fall", fall, 0);
      check("rst_busy", busy, 0);
      check("rst_toggle", tog, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // RATIO=1, STABLE_CNT=1: sync (2) + commit (1) -> rise in 3rd/4th cycle.
      btn_e = 1'b1;
      first = -1; nr = 0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); @(negedge clk);
         if (rise_e) begin nr++; if (first < 0) first = i; end
      end
      check("edge_rise_window", (first >= 3 && first <= 4), 1);
      check("edge_rise_cnt", nr, 1);
      check("edge_level", lvl_e, 1);

      press("press1", 1);
      release_btn("rel1");

      // Bounce: 15 cycles high cannot span 4 ticks.
      nr = 0; bs = 0;
      btn = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); @(negedge clk);
         if (rise) nr++;
         if (busy) bs = 1;
      end
      btn = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); @(negedge clk);
         if (rise) nr++;
      end
      check("bounce_rise_cnt", nr, 0);
      check("bounce_level", lvl, 0);
      check("bounce_busy_seen", bs, 1);
      check("bounce_busy_end", busy, 0);

      press("press2", 2);
      release_btn("rel2");
      press("press3", 3);
      release_btn("rel3");

      // Reset during S_LO2HI with the pin held high.
      btn = 1'b1;
      for (int i = 0; i < 30 && !busy; i++) begin
         @(posedge clk); @(negedge clk);
      end
      check("mid_busy_reached", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_outs", {lvl, rise, fall, busy, tog}, 0);
      repeat (3) @(negedge clk);
      check("mid_rst_held", {lvl, rise, fall, busy, tog}, 0);
      rst_n = 1'b1;
      // Counter restarts at 0: ticks at edges 10,20,30,40 -> rise after edge 40.
      at = -1;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); @(negedge clk);
         if (rise) begin at = i; break; end
      end
      check("mid_requal_rise_at", at, 40);
      check("mid_requal_level", lvl, 1);
      check("mid_requal_toggle", tog, TOG_EN ? 1 : 0);

      check("rise_fall_overlap", overlap_seen, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pin_debouncer.md
PIN_DEBOUNCER -- requirements
Module: pin_debouncer

Interface
REQ-001 SHALL have parameter RATIO, default 10: sample-tick divider in pin_clk cycles; legal range 1..2^16.
REQ-002 SHALL have parameter STABLE_CNT, default 4: consecutive differing ticks needed to commit a new level; legal range 1..255.
REQ-003 SHALL have port pin_clk  input  1  system clock; all state on its rising edge.
REQ-004 SHALL have port pin_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pin_btn  input  1  raw asynchronous pin, possibly bouncing.
REQ-006 SHALL have port btn_level  output  1  debounced, committed level.
REQ-007 SHALL have port btn_rise  output  1  one-cycle pulse on a committed 0->1 change.
REQ-008 SHALL have port btn_fall  output  1  one-cycle pulse on a committed 1->0 change.
REQ-009 SHALL have port btn_busy  output  1  high while a level change is being qualified.
REQ-010 SHALL have port btn_toggle  output  1  level flipped on each committed rise (see Configuration).

Function
REQ-011 SHALL pass pin_btn through a two-flop synchronizer; only its second-stage output (sync) is used downstream.
REQ-012 SHALL run a tick counter 0..RATIO-1, wrapping to 0; tick is high for exactly the one cycle when counter == RATIO-1; RATIO=1 gives tick every cycle.
REQ-013 SHALL implement FSM states S_LO, S_LO2HI, S_HI, S_HI2LO; state and counters change only on tick cycles.
REQ-014 SHALL, in S_LO on tick with sync=1, set stab=1 and go to S_LO2HI; if STABLE_CNT=1, go directly to S_HI and commit.
REQ-015 SHALL, in S_LO2HI on tick: sync=1 increments stab, and reaching STABLE_CNT commits to S_HI; sync=0 clears stab and returns to S_LO with no output pulse.
REQ-016 SHALL implement S_HI and S_HI2LO symmetrically with sync=0 as the differing value.
REQ-017 SHALL update btn_level in the cycle after the committing tick, with btn_rise or btn_fall high for exactly that one cycle.
REQ-018 SHALL assert btn_busy exactly while the state is S_LO2HI or S_HI2LO.
REQ-019 SHALL size stab as 8 bits; stab never exceeds STABLE_CNT and never wraps.
REQ-020 SHALL guarantee btn_rise and btn_fall are never high together, and at least STABLE_CNT ticks separate consecutive pulses.
REQ-021 SHALL bound worst-case commit latency from a clean pin_btn edge to btn_level change at 2 + STABLE_CNT*RATIO + 1 cycles.

Reset
REQ-022 SHALL, while pin_rst=0, asynchronously clear synchronizer flops, tick counter, stab, btn_level, btn_rise, btn_fall, btn_busy and btn_toggle, and set FSM to S_LO.
REQ-023 SHALL, when reset asserts mid-qualification, abandon the pending change with no pulse; after release, a held-high pin_btn is requalified from stab=0.
REQ-024 SHALL restart the tick counter at 0 on reset release, so the first tick occurs RATIO cycles later.

Configuration
REQ-025 SHALL, with PIN_DEBOUNCER_TOGGLE_EN defined, flip btn_toggle registered in the same cycle btn_rise is high, and leave it unchanged on btn_fall.
REQ-026 SHALL, without PIN_DEBOUNCER_TOGGLE_EN, keep port btn_toggle present, tie it constant 0, and instantiate no toggle flop.

Verification
REQ-027 SHALL cover clean press: RATIO=10, STABLE_CNT=4, pin_btn 0->1 held -> exactly one btn_rise, btn_level=1 within 43 cycles, btn_busy high only during qualification.
REQ-028 SHALL cover bounce rejection: pin_btn high for 15 cycles then low -> no btn_rise, btn_level stays 0, btn_busy returns low.
REQ-029 SHALL cover release: from btn_level=1, pin_btn held 0 -> one btn_fall, btn_level=0 within 43 cycles, btn_rise never high.
REQ-030 SHALL cover reset mid-operation: pin_rst low for 3 cycles during S_LO2HI with pin_btn still high -> all outputs 0 immediately, then a btn_rise only after a full 4-tick requalification.
REQ-031 SHALL cover edge parameters: RATIO=1, STABLE_CNT=1, pin_btn 0->1 -> btn_rise pulse 4 cycles after the edge.
REQ-032 SHALL cover toggle: with PIN_DEBOUNCER_TOGGLE_EN, three clean presses -> btn_toggle reads 1,0,1; without the macro btn_toggle stays 0.
